// File: rtl/knob_quadrature_decoder.sv
// Turns the raw two-phase quadrature signals into one-cycle up/down notch pulses.
// Path: two-flop synchroniser, per-phase debounce filter, Gray-code step
// decode, and a signed sub-step accumulator.
// Illegal transitions (both phases changing together) raise a one-cycle err.
// For the first three cycles after reset the filtered phases load the
// synchronised inputs directly. The input position present at reset therefore
// never produces a step.
module knob_quadrature_decoder #(
    parameter int DEBOUNCE        = 4,
    parameter int STEPS_PER_NOTCH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic quad_a,
    input  logic quad_b,
    output logic up,
    output logic down,
    output logic err
);

    localparam logic [3:0]        CNT_LAST = 4'(DEBOUNCE - 1);
    localparam logic signed [3:0] ACC_MAX  = 4'(STEPS_PER_NOTCH - 1);
    localparam logic signed [3:0] ACC_MIN  = -ACC_MAX;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_init_cnt;

    logic              r_a_meta;
    logic              r_a_sync;
    logic              r_b_meta;
    logic              r_b_sync;

    logic              r_fa;
    logic              r_fb;
    logic [3:0]        r_cnt_a;
    logic [3:0]        r_cnt_b;
    logic [1:0]        r_f_prev;
    logic signed [3:0] r_acc;

    logic              r_up;
    logic              r_down;
    logic              r_err;

    logic [4:0]        w_deb_a;
    logic [4:0]        w_deb_b;
    logic [1:0]        w_step;
    logic              w_inc;
    logic              w_dec;
    logic              w_ill;

    // Gray position index along the clockwise sequence 00,01,11,10.
    function automatic logic [1:0] gray_idx(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // One debounce update, packed as {filtered, counter}.
    function automatic logic [4:0] debounce(input logic s, input logic f,
                                            input logic [3:0] cnt);
        logic [4:0] res;
        if (s == f) begin
            res = {f, 4'd0};
        end else if (cnt == CNT_LAST) begin
            res = {s, 4'd0};
        end else begin
            res = {f, cnt + 4'd1};
        end
        return res;
    endfunction

    // Two-flop synchroniser for each raw phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
        end else begin
            r_a_meta <= quad_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= quad_b;
            r_b_sync <= r_b_meta;
        end
    end

    // FSM state register and INIT cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 2'd1;
            end
        end
    end

    // Next state: leave INIT after its third cycle; RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == 2'd2) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Debounce candidates and step decode of the filtered phase pair.
    always_comb begin
        w_deb_a = debounce(r_a_sync, r_fa, r_cnt_a);
        w_deb_b = debounce(r_b_sync, r_fb, r_cnt_b);
        w_step  = gray_idx({r_fa, r_fb}) - gray_idx(r_f_prev);
        w_inc   = 1'b0;
        w_dec   = 1'b0;
        w_ill   = 1'b0;
        if (r_state == ST_RUN) begin
            w_inc = (w_step == 2'd1);
            w_dec = (w_step == 2'd3);
            w_ill = (w_step == 2'd2);
        end
    end

    // Filtered phases, debounce counters and previous-pair register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fa     <= 1'b0;
            r_fb     <= 1'b0;
            r_cnt_a  <= 4'd0;
            r_cnt_b  <= 4'd0;
            r_f_prev <= 2'b00;
        end else if (r_state == ST_INIT) begin
            r_fa     <= r_a_sync;
            r_fb     <= r_b_sync;
            r_cnt_a  <= 4'd0;
            r_cnt_b  <= 4'd0;
            r_f_prev <= {r_a_sync, r_b_sync};
        end else begin
            r_fa     <= w_deb_a[4];
            r_cnt_a  <= w_deb_a[3:0];
            r_fb     <= w_deb_b[4];
            r_cnt_b  <= w_deb_b[3:0];
            r_f_prev <= {r_fa, r_fb};
        end
    end

    // Sub-step accumulator and the registered single-cycle event pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= 4'sd0;
            r_up   <= 1'b0;
            r_down <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_up   <= 1'b0;
            r_down <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == ST_INIT) begin
                r_acc <= 4'sd0;
            end else if (w_ill) begin
                r_err <= 1'b1;
                r_acc <= 4'sd0;
            end else if (w_inc) begin
                if (r_acc == ACC_MAX) begin
                    r_up  <= 1'b1;
                    r_acc <= 4'sd0;
                end else begin
                    r_acc <= r_acc + 4'sd1;
                end
            end else if (w_dec) begin
                if (r_acc == ACC_MIN) begin
                    r_down <= 1'b1;
                    r_acc  <= 4'sd0;
                end else begin
                    r_acc <= r_acc - 4'sd1;
                end
            end
        end
    end

    assign up   = r_up;
    assign down = r_down;
    assign err  = r_err;

endmodule

// File: tb/tb_knob_quadrature_decoder.sv
// Directed testbench for knob_quadrature_decoder (default parameters).
// Inputs are driven on the falling edge. A falling-edge monitor counts
// pulses, flags overlapping or wide pulses, and keeps a simple lock position.
module tb_knob_quadrature_decoder;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic quad_a  = 1'b0;
    logic quad_b  = 1'b0;
    logic up;
    logic down;
    logic err;

    int cyc         = 0;
    int n_up        = 0;
    int n_down      = 0;
    int n_err       = 0;
    int viol        = 0;
    int last_up_cyc = -1;
    int lock_pos    = 0;
    int total       = 0;
    int bad         = 0;
    int t_edge      = 0;
    logic prev_up   = 1'b0;
    logic prev_down = 1'b0;
    logic prev_err  = 1'b0;

    int b_up;
    int b_down;
    int b_err;

    knob_quadrature_decoder #(.DEBOUNCE(4), .STEPS_PER_NOTCH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .up      (up),
        .down    (down),
        .err     (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: counts, width/overlap violations, lock position.
    always @(negedge clock) begin
        if (up) begin
            n_up++;
            last_up_cyc = cyc;
        end
        if (down) n_down++;
        if (err) n_err++;
        if ((up && prev_up) || (down && prev_down) || (err && prev_err)) viol++;
        if ((int'(up) + int'(down) + int'(err)) > 1) viol++;
        if (!reset_n) lock_pos = 0;
        else lock_pos = lock_pos + int'(up) - int'(down);
        prev_up   = up;
        prev_down = down;
        prev_err  = err;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive raw {A,B} on a falling edge and hold it for n cycles.
    task automatic drive(input logic [1:0] ab, input int n);
        @(negedge clock);
        {quad_a, quad_b} = ab;
        t_edge = cyc;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic snap();
        b_up   = n_up;
        b_down = n_down;
        b_err  = n_err;
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(negedge clock);
        reset_n = 1'b0;
        {quad_a, quad_b} = ab;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        settle(8);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_up", int'(up), 0);
        check_eq("rst_down", int'(down), 0);
        check_eq("rst_err", int'(err), 0);
        @(negedge clock);
        reset_n = 1'b1;
        settle(8);

        // One clockwise notch, with latency from the final 00 edge
        snap();
        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);
        settle(10);
        check_eq("cw_up", n_up - b_up, 1);
        check_eq("cw_down", n_down - b_down, 0);
        check_eq("cw_err", n_err - b_err, 0);
        check_eq("cw_latency", last_up_cyc - t_edge, 7);
        check_eq("cw_viol", viol, 0);

        // One counterclockwise notch
        snap();
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        settle(10);
        check_eq("ccw_down", n_down - b_down, 1);
        check_eq("ccw_up", n_up - b_up, 0);
        check_eq("ccw_err", n_err - b_err, 0);

        // Three-cycle glitch on A is filtered out
        snap();
        drive(2'b10, 3);
        drive(2'b00, 15);
        settle(2);
        check_eq("glitch_up", n_up - b_up, 0);
        check_eq("glitch_down", n_down - b_down, 0);
        check_eq("glitch_err", n_err - b_err, 0);

        // Reversal mid-notch: two CW, two CCW, then a full CW notch
        snap();
        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        settle(10);
        check_eq("rev_mid_up", n_up - b_up, 0);
        check_eq("rev_mid_down", n_down - b_down, 0);
        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);
        settle(10);
        check_eq("rev_end_up", n_up - b_up, 1);
        check_eq("rev_end_down", n_down - b_down, 0);

        // Both phases switch together: illegal, then a clean CW notch from 11
        snap();
        drive(2'b11, 10);
        settle(2);
        check_eq("ill_err", n_err - b_err, 1);
        check_eq("ill_up", n_up - b_up, 0);
        check_eq("ill_down", n_down - b_down, 0);
        drive(2'b10, 10);
        drive(2'b00, 10);
        drive(2'b01, 10);
        drive(2'b11, 10);
        settle(10);
        check_eq("ill_after_up", n_up - b_up, 1);
        check_eq("ill_after_err", n_err - b_err, 1);

        // Reset mid-notch discards the partial notch
        do_reset(2'b00);
        snap();
        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_up", int'(up), 0);
        check_eq("midrst_down", int'(down), 0);
        check_eq("midrst_err", int'(err), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        settle(8);
        check_eq("midrst_init_err", n_err - b_err, 0);
        drive(2'b00, 10);
        settle(10);
        check_eq("midrst_step_up", n_up - b_up, 0);
        check_eq("midrst_step_down", n_down - b_down, 0);

        // Integration: twelve CW notches move the lock to 12
        do_reset(2'b00);
        snap();
        for (int k = 0; k < 12; k++) begin
            drive(2'b01, 10);
            drive(2'b11, 10);
            drive(2'b10, 10);
            drive(2'b00, 10);
        end
        settle(10);
        check_eq("int_up", n_up - b_up, 12);
        check_eq("int_err", n_err - b_err, 0);
        check_eq("int_lock_pos", lock_pos, 12);
        check_eq("final_viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
